// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg
// Shared AXI4-Lite definitions: response codes, the configuration record,
// the register-master FSM state type and the command record.
// No ports; imported by axi4_lite_register_master.
package axi4_lite_pkg;

    // Bus geometry record used to size the command record.
    typedef struct packed {
        int addr_w;      // address width in bits
        int data_bytes;  // data bus width in bytes
    } cfg_t;

    localparam cfg_t DEFAULT_CFG = '{addr_w: 32, data_bytes: 4};

    // BRESP / RRESP encodings.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Register-master FSM states.
    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } master_state_e;

    // One command as presented on the command stream.
    typedef struct packed {
        logic                                   wr;
        logic [DEFAULT_CFG.addr_w-1:0]          addr;
        logic [DEFAULT_CFG.data_bytes*8-1:0]    wdata;
        logic [DEFAULT_CFG.data_bytes-1:0]      wstrb;
    } cmd_t;

endpackage

// File: rtl/axi4_lite_register_master.sv
// axi4_lite_register_master
// Single-outstanding AXI4-Lite initiator. Each command accepted on the
// cmd_* stream becomes one AW/W/B or AR/R transaction; exactly one response
// is returned on the rsp_* stream per command.
//
// Ports:
//   aclk, areset         clock; synchronous active-high reset
//   cmd_valid/ready      command handshake; cmd_wr, cmd_addr, cmd_wdata,
//                        cmd_wstrb carry the command
//   rsp_valid/ready      response handshake; rsp_wr, rsp_rdata, rsp_resp
//   aw*, w*, b*          AXI4-Lite write address / data / response channels
//   ar*, r*              AXI4-Lite read address / data channels
//
// Optional build macro AXI4_LITE_REGISTER_MASTER_STATS_EN adds the
// wr_count, rd_count and err_count transaction counters.
module axi4_lite_register_master
    import axi4_lite_pkg::*;
#(
    parameter int A = 32,
    parameter int N = 4
) (
    input  logic             aclk,
    input  logic             areset,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [A-1:0]     cmd_addr,
    input  logic [N*8-1:0]   cmd_wdata,
    input  logic [N-1:0]     cmd_wstrb,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_wr,
    output logic [N*8-1:0]   rsp_rdata,
    output logic [1:0]       rsp_resp,

    output logic [A-1:0]     awaddr,
    output logic [2:0]       awprot,
    output logic             awvalid,
    input  logic             awready,

    output logic [N*8-1:0]   wdata,
    output logic [N-1:0]     wstrb,
    output logic             wvalid,
    input  logic             wready,

    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready,

    output logic [A-1:0]     araddr,
    output logic [2:0]       arprot,
    output logic             arvalid,
    input  logic             arready,

    input  logic [N*8-1:0]   rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready
`ifdef AXI4_LITE_REGISTER_MASTER_STATS_EN
    ,
    output logic [31:0]      wr_count,
    output logic [31:0]      rd_count,
    output logic [31:0]      err_count
`endif
);

    master_state_e state;
    master_state_e state_next;

    // AW and W complete independently; each flag clears on its own handshake.
    logic aw_pend;
    logic w_pend;

    logic cmd_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic r_fire;

    assign cmd_ready = (state == IDLE) & ~areset;
    assign cmd_fire  = cmd_valid & cmd_ready;

    assign awvalid   = aw_pend;
    assign wvalid    = w_pend;
    assign arvalid   = (state == RD_AR);
    assign bready    = (state == WR_B);
    assign rready    = (state == RD_R);
    assign rsp_valid = (state == RSP);
    assign awprot    = 3'b000;
    assign arprot    = 3'b000;

    assign aw_fire   = awvalid & awready;
    assign w_fire    = wvalid & wready;
    // bready/rready are only high in WR_B/RD_R, so B and R are ignored elsewhere.
    assign b_fire    = bvalid & bready;
    assign r_fire    = rvalid & rready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is assigned a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = cmd_wr ? WR_AW_W : RD_AR;
            // Leave once each channel has either already completed or
            // completes in this cycle.
            WR_AW_W: if ((aw_fire | ~aw_pend) & (w_fire | ~w_pend)) state_next = WR_B;
            WR_B:    if (b_fire) state_next = RSP;
            RD_AR:   if (arready) state_next = RD_R;
            RD_R:    if (r_fire) state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= OKAY;
            rsp_wr    <= 1'b0;
        end else begin
            if (cmd_fire) begin
                if (cmd_wr) begin
                    awaddr  <= cmd_addr;
                    wdata   <= cmd_wdata;
                    wstrb   <= cmd_wstrb;
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                end else begin
                    araddr  <= cmd_addr;
                end
            end
            if (aw_fire) aw_pend <= 1'b0;
            if (w_fire)  w_pend  <= 1'b0;
            if (b_fire) begin
                rsp_resp  <= bresp;
                rsp_rdata <= '0;
                rsp_wr    <= 1'b1;
            end
            if (r_fire) begin
                rsp_resp  <= rresp;
                rsp_rdata <= rdata;
                rsp_wr    <= 1'b0;
            end
        end
    end

`ifdef AXI4_LITE_REGISTER_MASTER_STATS_EN
    // Free-running counters; they wrap naturally at 2^32.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            if (b_fire) wr_count <= wr_count + 32'd1;
            if (r_fire) rd_count <= rd_count + 32'd1;
            if ((b_fire && bresp != OKAY) || (r_fire && rresp != OKAY)) begin
                err_count <= err_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi4_lite_register_master.sv
// tb_axi4_lite_register_master
// Self-checking bench: a behavioural AXI4-Lite slave with per-channel
// delays, a command-level reference model (register image plus an
// address-based response rule), directed scenarios and a randomized phase.
module tb_axi4_lite_register_master;
    import axi4_lite_pkg::*;

    logic        clk = 1'b0;
    logic        areset = 1'b1;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
`ifdef AXI4_LITE_REGISTER_MASTER_STATS_EN
    logic [31:0] wr_count, rd_count, err_count;
`endif

    axi4_lite_register_master #(.A(32), .N(4)) dut (
        .aclk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef AXI4_LITE_REGISTER_MASTER_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (command level) ----------------
    logic [31:0] rmem [logic [31:0]];
    int m_wr = 0, m_rd = 0, m_err = 0;

    function automatic logic [1:0] resp_rule(input logic [31:0] a);
        case (a[11:8])
            4'hE:    return SLVERR;
            4'hF:    return DECERR;
            default: return OKAY;
        endcase
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    // ---------------- behavioural slave ----------------
    logic [31:0] smem [logic [31:0]];
    bit  rand_mode = 0;
    int  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int  aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit  aw_got = 0, w_got = 0, ar_got = 0;
    bit  aw_fire = 0, w_fire = 0, ar_fire = 0, b_fire = 0, r_fire = 0;
    bit  wr_active = 0, rd_active = 0, acc_pending = 0;
    logic        exp_wr = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    int  aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_cyc = 0;
    int  t_acc = 0, t_rsp = 0;

    task automatic pick_delays();
        if (rand_mode) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
            b_dly  = $urandom_range(0, 4); ar_dly = $urandom_range(0, 4);
            r_dly  = $urandom_range(0, 4);
        end
    endtask

    initial begin : slave
        forever begin
            @(negedge clk);
            if (areset) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                bresp = '0; rresp = '0; rdata = '0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
                wr_active = 0; rd_active = 0; acc_pending = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                // Retire transfers that completed on the last rising edge.
                if (b_fire) begin
                    if (bresp == OKAY)
                        smem[s_awaddr] = merge(smem.exists(s_awaddr) ? smem[s_awaddr]
                                               : init_val(s_awaddr), s_wdata, s_wstrb);
                    bvalid = 0; bresp = '0; b_fire = 0;
                    aw_got = 0; w_got = 0; wr_active = 0;
                    aw_wait = 0; w_wait = 0; b_wait = 0;
                    pick_delays();
                end
                if (r_fire) begin
                    rvalid = 0; rresp = '0; rdata = '0; r_fire = 0;
                    ar_got = 0; rd_active = 0; ar_wait = 0; r_wait = 0;
                    pick_delays();
                end
                if (aw_fire) begin check("awvalid_drop", awvalid, 0); aw_fire = 0; end
                if (w_fire)  begin check("wvalid_drop", wvalid, 0);   w_fire = 0;  end
                if (ar_fire) begin check("arvalid_drop", arvalid, 0); ar_fire = 0; end
                if (acc_pending) begin
                    acc_pending = 0;
                    if (exp_wr) wr_active = 1; else rd_active = 1;
                end

                // Protocol and payload checks for the current cycle.
                if (wr_active && !aw_got) check("awvalid_hold", awvalid, 1);
                if (wr_active && !w_got)  check("wvalid_hold", wvalid, 1);
                if (rd_active && !ar_got) check("arvalid_hold", arvalid, 1);
                if (awvalid) check("awaddr", awaddr, exp_addr);
                if (wvalid) begin
                    check("wdata", wdata, exp_wdata);
                    check("wstrb", wstrb, exp_wstrb);
                end
                if (arvalid) check("araddr", araddr, exp_addr);
                if (awvalid || wvalid) check("bready_early", bready, 0);
                if (arvalid) check("rready_early", rready, 0);

                // Responses only after the address (and data) handshakes.
                if (wr_active && aw_got && w_got && !bvalid) begin
                    if (b_wait >= b_dly) begin bvalid = 1; bresp = resp_rule(s_awaddr); end
                    else b_wait++;
                end
                if (bvalid && bready) begin b_fire = 1; b_cyc = cyc; end
                if (rd_active && ar_got && !rvalid) begin
                    if (r_wait >= r_dly) begin
                        rvalid = 1; rresp = resp_rule(s_araddr);
                        rdata = smem.exists(s_araddr) ? smem[s_araddr] : init_val(s_araddr);
                    end else r_wait++;
                end
                if (rvalid && rready) r_fire = 1;

                awready = 0; wready = 0; arready = 0;
                if (awvalid && !aw_got) begin
                    if (aw_wait >= aw_dly) begin
                        awready = 1; aw_got = 1; aw_fire = 1; s_awaddr = awaddr; aw_cyc = cyc;
                    end else aw_wait++;
                end
                if (wvalid && !w_got) begin
                    if (w_wait >= w_dly) begin
                        wready = 1; w_got = 1; w_fire = 1; s_wdata = wdata; s_wstrb = wstrb;
                        w_cyc = cyc;
                    end else w_wait++;
                end
                if (arvalid && !ar_got) begin
                    if (ar_wait >= ar_dly) begin
                        arready = 1; ar_got = 1; ar_fire = 1; s_araddr = araddr; ar_cyc = cyc;
                    end else ar_wait++;
                end

                if (cmd_valid && cmd_ready) begin
                    acc_pending = 1; exp_wr = cmd_wr; exp_addr = cmd_addr;
                    exp_wdata = cmd_wdata; exp_wstrb = cmd_wstrb;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, output bit ok);
        int n;
        cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (cmd_ready) ok = 1; else n++;
        end
        if (ok) t_acc = cyc; else check({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input string tag, input int hold, input logic e_wr,
                            input logic [31:0] e_rdata, input logic [1:0] e_resp, output bit ok);
        int n;
        ok = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (rsp_valid) ok = 1; else n++;
        end
        if (!ok) begin
            check({tag, "_rsp_timeout"}, 0, 1);
            return;
        end
        t_rsp = cyc;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check({tag, "_rsp_valid_hold"}, rsp_valid, 1);
            end
            check({tag, "_cmd_ready_busy"}, cmd_ready, 0);
            check({tag, "_rsp_wr"}, rsp_wr, e_wr);
            check({tag, "_rsp_rdata"}, rsp_rdata, e_rdata);
            check({tag, "_rsp_resp"}, rsp_resp, e_resp);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int hold);
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        bit ok;
        e_resp  = resp_rule(addr);
        e_rdata = wr ? 32'h0 : ref_read(addr);
        issue(tag, wr, addr, data, strb, ok);
        if (ok) begin
            wait_rsp(tag, hold, wr, e_rdata, e_resp, ok);
            if (ok) begin
                if (wr && e_resp == OKAY) rmem[addr] = merge(ref_read(addr), data, strb);
                if (wr) m_wr++; else m_rd++;
                if (e_resp != OKAY) m_err++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"}, wvalid, 0);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_bready"}, bready, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_awaddr"}, awaddr, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_wstrb"}, wstrb, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_resp"}, rsp_resp, 0);
        check({tag, "_rsp_wr"}, rsp_wr, 0);
        check({tag, "_prot"}, {awprot, arprot}, 0);
        check({tag, "_cmd_ready_in_reset"}, cmd_ready, 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin : main
        bit ok;
        int n;
        logic [31:0] a;

        smem[32'h4] = 32'h1234_5678;
        rmem[32'h4] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        areset = 0;
        #1;
        check("reset_cmd_ready", cmd_ready, 1);

        // Write with an always-ready slave: minimum latency.
        run_cmd("t1", 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0);
        check("t1_aw_cycle", aw_cyc - t_acc, 1);
        check("t1_w_cycle", w_cyc - t_acc, 1);
        check("t1_latency", t_rsp - t_acc, 3);

        // Read of a preloaded location.
        run_cmd("t2", 1'b0, 32'h0000_0004, 32'h0, 4'h0, 0);
        check("t2_araddr", s_araddr, 32'h4);
        check("t2_ar_cycle", ar_cyc - t_acc, 1);
        check("t2_latency", t_rsp - t_acc, 3);

        // W completes three cycles before AW.
        aw_dly = 5; w_dly = 2;
        run_cmd("t3", 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h5, 0);
        check("t3_w_before_aw", aw_cyc - w_cyc, 3);
        check("t3_b_after_aw", b_cyc > aw_cyc, 1);
        aw_dly = 0; w_dly = 0;

        // SLVERR read held on the response stream for four cycles.
        run_cmd("t4", 1'b0, 32'h0000_0E04, 32'h0, 4'h0, 4);

        // Reset while waiting for B.
        b_dly = 10;
        issue("t5", 1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, ok);
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bready) ok = 1; else n++;
        end
        check("t5_reached_wr_b", ok, 1);
        @(posedge clk); #1;
        areset = 1;
        @(posedge clk); #1;
        check_reset_outputs("t5");
        areset = 0;
        m_wr = 0; m_rd = 0; m_err = 0;
        #1;
        check("t5_cmd_ready", cmd_ready, 1);
        b_dly = 0;
`ifdef AXI4_LITE_REGISTER_MASTER_STATS_EN
        check("t5_wr_count", wr_count, 0);
        check("t5_err_count", err_count, 0);
`endif

        // Counter scenario: two writes (one SLVERR) and three reads.
        run_cmd("s_w0", 1'b1, 32'h0000_000C, 32'h0BAD_CAFE, 4'hF, 0);
        run_cmd("s_w1", 1'b1, 32'h0000_0E10, 32'h5555_AAAA, 4'hF, 1);
        run_cmd("s_r0", 1'b0, 32'h0000_000C, 32'h0, 4'h0, 0);
        run_cmd("s_r1", 1'b0, 32'h0000_0004, 32'h0, 4'h0, 2);
        run_cmd("s_r2", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0);
`ifdef AXI4_LITE_REGISTER_MASTER_STATS_EN
        check("s_wr_count", wr_count, 2);
        check("s_rd_count", rd_count, 3);
        check("s_err_count", err_count, 1);
`endif

        // Randomized traffic.
        rand_mode = 1;
        pick_delays();
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 19);
            if (n < 16)       a = 32'(n) * 32'd4;
            else if (n < 18)  a = 32'h0000_0E00 + 32'($urandom_range(0, 3)) * 32'd4;
            else              a = 32'h0000_0F00 + 32'($urandom_range(0, 3)) * 32'd4;
            run_cmd("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3));
        end
`ifdef AXI4_LITE_REGISTER_MASTER_STATS_EN
        check("final_wr_count", wr_count, 32'(m_wr));
        check("final_rd_count", rd_count, 32'(m_rd));
        check("final_err_count", err_count, 32'(m_err));
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
